tc_product_scaler: RTL and testbench

Pipelined multiply-round-saturate stage for the L1L2F tracklet calculator. It takes an unsigned 16-bit operand and a signed 18-bit operand with a valid/ready handshake and forms their full-precision signed product. It rounds the product half-up, arithmetic-shifts it right by a fixed amount and saturates it to a signed output field. It sits directly downstream of the operand fetch and feeds the tracklet parameter packer, replacing a bare product tap with a fixed-point result that stalls under backpressure.

---
 rtl/tc_pkg.sv | 27 ++
 rtl/tc_mul_16u_18s.sv | 13 +
 rtl/tc_product_scaler.sv | 127 ++++++++++++
 tb/tb_tc_product_scaler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the tracklet-calculator scaler stages: widths,
// default parameters and a reusable signed clamp.
package tc_pkg;

  localparam int PROD_W    = 34;
  localparam int EXT_W     = PROD_W + 1;
  localparam int SHIFT_DEF = 14;
  localparam int OUT_W_DEF = 14;
  localparam int TAG_W_DEF = 7;
  localparam int CNT_W     = 16;

  // Clamps x to the signed range of an out_w-bit field. The result is still
  // EXT_W wide; callers take the low out_w bits.
  function automatic logic signed [EXT_W-1:0] sat_clamp(
    input logic signed [EXT_W-1:0] x,
    input int unsigned             out_w
  );
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi = $signed((EXT_W'(1) << (out_w - 1)) - EXT_W'(1));
    lo = ~hi;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/tc_mul_16u_18s.sv
// Combinational 16-bit unsigned by 18-bit signed multiply, full 34-bit result.
// Kept bare so the product register downstream folds into the DSP P register.
module tc_mul_16u_18s
  import tc_pkg::*;
(
  input  logic        [15:0]       a,
  input  logic signed [17:0]       b,
  output logic signed [PROD_W-1:0] p
);

  assign p = PROD_W'($signed({1'b0, a})) * PROD_W'(b);

endmodule

// File: rtl/tc_product_scaler.sv
// Three-stage multiply / round-half-up / shift / saturate pipeline with a
// global stall and a saturating count of clamped results.
module tc_product_scaler
  import tc_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      din0,
  input  logic [17:0]      din1,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] dout,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_sat,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  logic                     en;
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        [15:0]       a1_q, a1_d;
  logic signed [17:0]       b1_q, b1_d;
  logic        [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic signed [PROD_W-1:0] prod_w, prod_q, prod_d;
  logic signed [EXT_W-1:0]  rnd, rs, clamped;
  logic        [OUT_W-1:0]  dout_q, dout_d;
  logic                     sat_q, sat_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;

  // The whole pipe freezes only when a result is waiting and not taken.
  assign en      = !(v3_q && !m_ready);
  assign s_ready = en;

  tc_mul_16u_18s u_mul (
    .a (a1_q),
    .b (b1_q),
    .p (prod_w)
  );

  always_comb begin
    rnd     = EXT_W'(prod_q) + (EXT_W'(1) << (SHIFT - 1));
    rs      = rnd >>> SHIFT;
    clamped = sat_clamp(rs, OUT_W);
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    prod_d = prod_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    dout_d = dout_q;
    sat_d  = sat_q;
    tag3_d = tag3_q;
    if (en) begin
      v1_d   = s_valid;
      a1_d   = din0;
      b1_d   = $signed(din1);
      tag1_d = s_tag;
      v2_d   = v1_q;
      prod_d = prod_w;
      tag2_d = tag1_q;
      v3_d   = v2_q;
      dout_d = OUT_W'(clamped);
      sat_d  = (clamped != rs);
      tag3_d = tag2_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (v3_q && m_ready && sat_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      dout_q <= '0;
      sat_q  <= 1'b0;
      tag3_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      prod_q <= prod_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
      tag3_q <= tag3_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_valid   = v3_q;
  assign dout      = dout_q;
  assign m_tag     = tag3_q;
  assign m_sat     = sat_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_tc_product_scaler.sv
// Directed-vector bench for tc_product_scaler with default parameters
// (SHIFT = 14, OUT_W = 14, TAG_W = 7).
module tb_tc_product_scaler;

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        s_valid  = 1'b0;
  logic        m_ready  = 1'b1;
  logic        sat_clr  = 1'b0;
  logic [15:0] din0     = '0;
  logic [17:0] din1     = '0;
  logic [6:0]  s_tag    = '0;
  logic        s_ready;
  logic        m_valid;
  logic        m_sat;
  logic [13:0] dout;
  logic [6:0]  m_tag;
  logic [15:0] sat_count;

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  tc_product_scaler dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .din0      (din0),
    .din1      (din1),
    .s_tag     (s_tag),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .dout      (dout),
    .m_tag     (m_tag),
    .m_sat     (m_sat),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input int d0, input int d1, input int tag);
    din0  = d0[15:0];
    din1  = d1[17:0];
    s_tag = tag[6:0];
  endtask

  // One isolated transaction: checks 3-cycle latency, value, flag and tag.
  task automatic run_vec(input string name, input int d0, input int d1,
                         input int tag, input int exp_dout, input logic exp_sat);
    logic [13:0] e;
    logic [6:0]  et;
    e  = exp_dout[13:0];
    et = tag[6:0];
    m_ready = 1'b1;
    drive(d0, d1, tag);
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: m_valid=%b required 0 two edges after accept", name, m_valid);
    end
    tick;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: m_valid=%b required 1 three edges after accept", name, m_valid);
    end
    checks++;
    if (dout !== e) begin
      errors++;
      $display("FAIL %s dout: got %0d required %0d", name, $signed(dout), $signed(e));
    end
    checks++;
    if (m_sat !== exp_sat) begin
      errors++;
      $display("FAIL %s m_sat: got %b required %b", name, m_sat, exp_sat);
    end
    checks++;
    if (m_tag !== et) begin
      errors++;
      $display("FAIL %s m_tag: got %0d required %0d", name, m_tag, et);
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || dout !== 14'd0 || m_tag !== 7'd0 || m_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: m_valid=%b dout=%0d m_tag=%0d m_sat=%b required all 0",
               m_valid, dout, m_tag, m_sat);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat_count: got %0d required 0", sat_count);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b required 1", s_ready);
    end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_vec("basic", 16384, 100, 5, 100, 1'b0);
    tick;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_single: m_valid=%b required 0 after result taken", m_valid);
    end
  endtask

  task automatic test_rounding;
    run_vec("round_pos_half", 1, 8192, 6, 1, 1'b0);
    run_vec("round_neg_half", 1, -8192, 7, 0, 1'b0);
    run_vec("round_neg_over", 1, -8193, 8, -1, 1'b0);
  endtask

  task automatic test_saturation;
    run_vec("sat_pos", 65535, 131071, 3, 8191, 1'b1);
    run_vec("sat_neg", 65535, -131072, 4, -8192, 1'b1);
    tick;
    checks++;
    if (sat_count !== 16'd2) begin
      errors++;
      $display("FAIL sat_count_two: got %0d required 2", sat_count);
    end
  endtask

  // Ten inputs with tags 0..9 and din1 = 3*tag-10 scaled by 2^14, so each
  // result equals 3*tag-10. m_ready drops for 5 cycles at the first m_valid.
  task automatic test_back_to_back;
    int          in_idx, out_idx, stall_left, cyc;
    bit          seen, prev_stall, acc, take;
    logic [13:0] snap_d, e;
    logic [6:0]  snap_t;
    in_idx = 0; out_idx = 0; stall_left = 0; cyc = 0;
    seen = 1'b0; prev_stall = 1'b0;
    snap_d = '0; snap_t = '0;
    while (out_idx < 10 && cyc < 80) begin
      if (!seen && m_valid) begin
        seen       = 1'b1;
        stall_left = 5;
      end
      m_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      s_valid = (in_idx < 10);
      drive(16384, in_idx * 3 - 10, in_idx);
      #1;
      if (!m_ready) begin
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_s_ready: got %b required 0 at cycle %0d", s_ready, cyc);
        end
        if (prev_stall) begin
          checks++;
          if (dout !== snap_d || m_tag !== snap_t) begin
            errors++;
            $display("FAIL stall_stable: dout=%0d m_tag=%0d required dout=%0d m_tag=%0d",
                     $signed(dout), m_tag, $signed(snap_d), snap_t);
          end
        end
        snap_d     = dout;
        snap_t     = m_tag;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      acc  = s_valid && s_ready;
      take = m_valid && m_ready;
      if (take) begin
        e = 14'(out_idx * 3 - 10);
        checks++;
        if (m_tag !== out_idx[6:0] || dout !== e) begin
          errors++;
          $display("FAIL b2b_order: got tag=%0d dout=%0d required tag=%0d dout=%0d",
                   m_tag, $signed(dout), out_idx, $signed(e));
        end
        out_idx++;
      end
      @(posedge ap_clk);
      #1;
      if (acc) in_idx++;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (out_idx != 10) begin
      errors++;
      $display("FAIL b2b_count: delivered %0d required 10 within 80 cycles", out_idx);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dup: m_valid=%b required 0 after last result", m_valid);
    end
  endtask

  task automatic test_reset_mid;
    bit leaked;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16384, 7 + i, 1 + i);
      s_valid = 1'b1;
      tick;
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight: m_valid=%b required 1 before reset", m_valid);
    end
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || dout !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: m_valid=%b dout=%0d required 0 and 0", m_valid, dout);
    end
    tick;
    ap_rst_n = 1'b1;
    leaked = 1'b0;
    repeat (5) begin
      tick;
      if (m_valid !== 1'b0) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL mid_stale: stale result seen=%b required 0", leaked);
    end
    run_vec("post_reset", 16384, 42, 9, 42, 1'b0);
  endtask

  task automatic stream_sat(input int n);
    m_ready = 1'b1;
    drive(65535, 131071, 0);
    s_valid = 1'b1;
    repeat (n) tick;
    s_valid = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_sat_count;
    stream_sat(65534);
    checks++;
    if (sat_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL cnt_fffe: got %h required fffe", sat_count);
    end
    stream_sat(3);
    checks++;
    if (sat_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_hold: got %h required ffff", sat_count);
    end
    drive(65535, -131072, 11);
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (m_valid !== 1'b1 || m_sat !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: m_valid=%b m_sat=%b required 1 and 1", m_valid, m_sat);
    end
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d required 0", sat_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    test_sat_count;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
